// File: rtl/my_best_qh_pkg.sv
// Shared constants, node-memory layout and FSM encoding for the
// neighbour-table scanners (my_best_qh, bestNeighbors).
package my_best_qh_pkg;

  localparam int WORD_WIDTH = 16;
  localparam int MEM_DEPTH  = 2048;
  localparam int MEM_WIDTH  = 8;
  localparam int ADDR_WIDTH = $clog2(MEM_DEPTH);

  localparam logic [ADDR_WIDTH-1:0] COUNT_ADDR_DEF = 11'h000;
  localparam logic [ADDR_WIDTH-1:0] TABLE_BASE_DEF = 11'h002;

  localparam logic [ADDR_WIDTH-1:0] ENTRY_STRIDE = 11'd6;
  localparam logic [ADDR_WIDTH-1:0] OFS_ID       = 11'd0;
  localparam logic [ADDR_WIDTH-1:0] OFS_HOPS     = 11'd2;
  localparam logic [ADDR_WIDTH-1:0] OFS_Q        = 11'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CNTW,
    S_HOP,
    S_Q,
    S_DONE
  } state_e;

  function automatic logic [ADDR_WIDTH-1:0] entry_addr(
    input logic [ADDR_WIDTH-1:0] base,
    input logic [ADDR_WIDTH-1:0] idx,
    input logic [ADDR_WIDTH-1:0] ofs
  );
    return base + ENTRY_STRIDE * idx + ofs;
  endfunction

endpackage

// File: rtl/my_best_qh.sv
// Scans the neighbour table and reports the best (max) Q-value and
// the lowest hop count seen across all listed neighbours.
module my_best_qh
  import my_best_qh_pkg::*;
#(
  parameter logic [10:0] COUNT_ADDR    = COUNT_ADDR_DEF,
  parameter logic [10:0] TABLE_BASE    = TABLE_BASE_DEF,
  parameter int          MAX_NEIGHBORS = 16
) (
  input  logic        clock,
  input  logic        nrst,
  input  logic        en,
  input  logic        start,
  input  logic [15:0] data_in,
  output logic [10:0] address,
  output logic        done,
  output logic [15:0] mybestQ,
  output logic [15:0] mybestH
);

  localparam int IW = (MAX_NEIGHBORS > 1) ? $clog2(MAX_NEIGHBORS) : 1;
  localparam int CW = $clog2(MAX_NEIGHBORS + 1);
  localparam logic [15:0] CNT_MAX = 16'(MAX_NEIGHBORS);

  state_e          state_q, state_d;
  logic [10:0]     addr_q, addr_d;
  logic [IW-1:0]   index_q, index_d;
  logic [CW-1:0]   count_q, count_d;
  logic [15:0]     hops_q, hops_d;
  logic [15:0]     bestq_q, bestq_d;
  logic [15:0]     besth_q, besth_d;
  logic            done_q, done_d;

  logic [CW-1:0]   cnt_clamp;
  logic [CW-1:0]   idx_nxt;
  logic            last;

  // Clamp before latching so the table address can never run away.
  assign cnt_clamp = (data_in > CNT_MAX) ? CW'(MAX_NEIGHBORS)
                                         : data_in[CW-1:0];
  assign idx_nxt   = CW'(index_q) + CW'(1);
  assign last      = (idx_nxt == count_q);

  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (en) begin
      unique case (state_q)
        S_IDLE: if (start) state_d = S_CNTW;
        S_CNTW: state_d = (cnt_clamp == '0) ? S_DONE : S_HOP;
        S_HOP:  state_d = S_Q;
        S_Q:    state_d = last ? S_DONE : S_HOP;
        S_DONE: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    addr_d  = addr_q;
    index_d = index_q;
    count_d = count_q;
    hops_d  = hops_q;
    bestq_d = bestq_q;
    besth_d = besth_q;
    done_d  = done_q;
    if (en) begin
      done_d = (state_d == S_DONE);
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            addr_d  = COUNT_ADDR;
            index_d = '0;
            bestq_d = 16'h0000;
            besth_d = 16'hFFFF;
          end
        end
        S_CNTW: begin
          count_d = cnt_clamp;
          if (cnt_clamp != '0)
            addr_d = entry_addr(TABLE_BASE, 11'd0, OFS_HOPS);
        end
        S_HOP: begin
          hops_d = data_in;
          addr_d = addr_q + (OFS_Q - OFS_HOPS);
        end
        S_Q: begin
          if (data_in > bestq_q) bestq_d = data_in;
          if (hops_q < besth_q)  besth_d = hops_q;
          if (!last) begin
            index_d = IW'(idx_nxt);
            addr_d  = entry_addr(TABLE_BASE, 11'(idx_nxt), OFS_HOPS);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) begin
      addr_q  <= '0;
      index_q <= '0;
      count_q <= '0;
      hops_q  <= '0;
      bestq_q <= 16'h0000;
      besth_q <= 16'hFFFF;
      done_q  <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      index_q <= index_d;
      count_q <= count_d;
      hops_q  <= hops_d;
      bestq_q <= bestq_d;
      besth_q <= besth_d;
      done_q  <= done_d;
    end
  end

  assign address = addr_q;
  assign done    = done_q;
  assign mybestQ = bestq_q;
  assign mybestH = besth_q;

endmodule

// File: tb/tb_my_best_qh.sv
// Directed bench for my_best_qh: table of scans plus hand sequences
// for clamping, stall, and mid-scan reset.
module tb_my_best_qh;

  logic        clock = 1'b0;
  logic        nrst  = 1'b0;
  logic        en    = 1'b1;
  logic        start = 1'b0;
  logic [15:0] data_in;
  logic [10:0] address;
  logic        done;
  logic [15:0] mybestQ;
  logic [15:0] mybestH;

  logic [15:0] mem [0:1023];

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  assign data_in = mem[address[10:1]];

  my_best_qh dut (
    .clock   (clock),
    .nrst    (nrst),
    .en      (en),
    .start   (start),
    .data_in (data_in),
    .address (address),
    .done    (done),
    .mybestQ (mybestQ),
    .mybestH (mybestH)
  );

  typedef struct {
    int               n;
    logic [3:0][15:0] h;
    logic [3:0][15:0] q;
    logic [15:0]      exp_q;
    logic [15:0]      exp_h;
    int               stall_at;
    int               stall_len;
    int               busy_at;
  } vec_t;

  vec_t vecs [7];

  function automatic vec_t mk(
    input int n,
    input logic [15:0] h0, q0, h1, q1, h2, q2, h3, q3,
    input logic [15:0] eq, eh,
    input int sa, sl, ba
  );
    vec_t v;
    v.n = n;
    v.h = {h3, h2, h1, h0};
    v.q = {q3, q2, q1, q0};
    v.exp_q = eq;
    v.exp_h = eh;
    v.stall_at = sa;
    v.stall_len = sl;
    v.busy_at = ba;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) mem[i] = 16'(16'hA000 + i);
  endtask

  task automatic load_vec(input vec_t v);
    clear_mem();
    mem[0] = 16'(v.n);
    for (int i = 0; i < 4; i++) begin
      mem[1 + 3*i] = 16'(16'h0100 + i);
      mem[2 + 3*i] = v.h[i];
      mem[3 + 3*i] = v.q[i];
    end
  endtask

  task automatic scan(input int stall_at, input int stall_len,
                      input int busy_at, output int done_edge,
                      output int pulses, output logic [10:0] maxaddr,
                      output bit froze);
    logic [43:0] snap;
    done_edge = -1;
    pulses = 0;
    maxaddr = '0;
    froze = 1'b1;
    snap = '0;
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    for (int e = 1; e < 400; e++) begin
      @(negedge clock);
      start = (e == busy_at);
      en = !(stall_at >= 0 && e > stall_at && e <= stall_at + stall_len);
      @(posedge clock);
      #1;
      if (address > maxaddr) maxaddr = address;
      if (done) begin
        pulses++;
        if (done_edge < 0) done_edge = e;
      end
      if (e == stall_at) snap = {address, done, mybestQ, mybestH};
      if (stall_at >= 0 && e > stall_at && e <= stall_at + stall_len &&
          snap != {address, done, mybestQ, mybestH})
        froze = 1'b0;
      if (done_edge >= 0 && e >= done_edge + 3) break;
    end
    @(negedge clock);
    en = 1'b1;
    start = 1'b0;
  endtask

  int          de, np;
  logic [10:0] ma;
  bit          fz;

  initial begin
    vecs[0] = mk(3, 4, 100, 2, 300, 5, 200, 0, 0,
                 16'd300, 16'd2, -1, 0, -1);
    vecs[1] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,
                 16'h0000, 16'hFFFF, -1, 0, -1);
    vecs[2] = mk(1, 7, 16'h1234, 0, 0, 0, 0, 0, 0,
                 16'h1234, 16'd7, -1, 0, -1);
    vecs[3] = mk(3, 3, 300, 3, 300, 9, 5, 0, 0,
                 16'd300, 16'd3, -1, 0, 3);
    vecs[4] = mk(2, 16'hFFFF, 0, 16'hFFFF, 0, 0, 0, 0, 0,
                 16'h0000, 16'hFFFF, -1, 0, -1);
    vecs[5] = mk(4, 10, 16'hFFFF, 1, 1, 0, 2, 8, 3,
                 16'hFFFF, 16'd0, -1, 0, -1);
    vecs[6] = mk(3, 4, 100, 2, 300, 5, 200, 0, 0,
                 16'd300, 16'd2, 4, 5, -1);

    clear_mem();
    repeat (2) @(negedge clock);
    #1;
    chk("rst_addr", 32'(address), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_q", 32'(mybestQ), 32'h0);
    chk("rst_h", 32'(mybestH), 32'hFFFF);
    @(negedge clock);
    nrst = 1'b1;

    for (int i = 0; i < 7; i++) begin
      load_vec(vecs[i]);
      scan(vecs[i].stall_at, vecs[i].stall_len, vecs[i].busy_at,
           de, np, ma, fz);
      chk($sformatf("v%0d_lat", i), 32'(de),
          32'(2*vecs[i].n + 1 + vecs[i].stall_len));
      chk($sformatf("v%0d_pulses", i), 32'(np), 32'd1);
      chk($sformatf("v%0d_q", i), 32'(mybestQ), 32'(vecs[i].exp_q));
      chk($sformatf("v%0d_h", i), 32'(mybestH), 32'(vecs[i].exp_h));
      chk($sformatf("v%0d_maxaddr", i), 32'(ma), 32'(6*vecs[i].n));
      if (vecs[i].stall_at >= 0)
        chk($sformatf("v%0d_frozen", i), 32'(fz), 32'd1);
      repeat (3) @(negedge clock);
      chk($sformatf("v%0d_hold_q", i), 32'(mybestQ), 32'(vecs[i].exp_q));
      chk($sformatf("v%0d_hold_h", i), 32'(mybestH), 32'(vecs[i].exp_h));
    end

    // count of 40 must clamp to 16; entries past 15 would win if read
    clear_mem();
    mem[0] = 16'd40;
    for (int i = 0; i < 20; i++) begin
      mem[2 + 3*i] = (i < 16) ? 16'(50 + i) : 16'd0;
      mem[3 + 3*i] = (i < 16) ? 16'(10 + i) : 16'hFFFF;
    end
    scan(-1, 0, -1, de, np, ma, fz);
    chk("clamp_lat", 32'(de), 32'd33);
    chk("clamp_pulses", 32'(np), 32'd1);
    chk("clamp_q", 32'(mybestQ), 32'd25);
    chk("clamp_h", 32'(mybestH), 32'd50);
    chk("clamp_maxaddr", 32'(ma), 32'd96);

    // reset during entry 2 of the reference scan
    load_vec(vecs[0]);
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    repeat (5) @(posedge clock);
    @(negedge clock);
    nrst = 1'b0;
    #1;
    chk("mid_rst_addr", 32'(address), 32'h0);
    chk("mid_rst_q", 32'(mybestQ), 32'h0);
    chk("mid_rst_h", 32'(mybestH), 32'hFFFF);
    np = 0;
    for (int e = 0; e < 4; e++) begin
      @(posedge clock);
      #1;
      if (done) np++;
    end
    @(negedge clock);
    nrst = 1'b1;
    for (int e = 0; e < 4; e++) begin
      @(posedge clock);
      #1;
      if (done) np++;
    end
    chk("mid_rst_nodone", 32'(np), 32'd0);
    scan(-1, 0, -1, de, np, ma, fz);
    chk("post_rst_lat", 32'(de), 32'd7);
    chk("post_rst_q", 32'(mybestQ), 32'd300);
    chk("post_rst_h", 32'(mybestH), 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/my_best_qh.md
MY_BEST_QH -- requirements
Module: my_best_qh

Interface
REQ-001 Parameter COUNT_ADDR, default 11'h000, byte address of the neighbour-count word.
REQ-002 Parameter TABLE_BASE, default 11'h002, byte address of neighbour entry 0.
REQ-003 Parameter MAX_NEIGHBORS, default 16, upper clamp on neighbour count.
REQ-004 Port clock, input, 1, single clock; all state updates on the rising edge.
REQ-005 Port nrst, input, 1, asynchronous active-low reset.
REQ-006 Port en, input, 1, stage enable; low freezes all state.
REQ-007 Port start, input, 1, begin a scan; sampled only in S_IDLE with en high.
REQ-008 Port data_in, input, 16, memory read data, valid one cycle after address changes.
REQ-009 Port address, output, 11, registered byte read address to node memory.
REQ-010 Port done, output, 1, registered one-cycle pulse: results valid.
REQ-011 Port mybestQ, output, 16, maximum neighbour Q-value from the last scan.
REQ-012 Port mybestH, output, 16, minimum neighbour hop count from the last scan.

Function
REQ-013 Memory layout is fixed: 16-bit words at even byte addresses; entry i occupies TABLE_BASE+6i (neighbour ID, unread), +2 (hops), +4 (Q-value).
REQ-014 States are S_IDLE, S_CNTW, S_HOP, S_Q and S_DONE.
REQ-015 In S_IDLE, when start=1 and en=1: address<=COUNT_ADDR, index<=0, mybestQ<=16'h0000, mybestH<=16'hFFFF, next state S_CNTW.
REQ-016 In S_CNTW: latch count=min(data_in, MAX_NEIGHBORS); if count=0, go to S_DONE; else address<=TABLE_BASE+2 and go to S_HOP.
REQ-017 In S_HOP: latch hops<=data_in, address<=address+2, go to S_Q.
REQ-018 In S_Q: if data_in>mybestQ (unsigned), mybestQ<=data_in; if latched hops<mybestH (unsigned), mybestH<=hops.
REQ-019 In S_Q: if index=count-1, go to S_DONE; else index<=index+1, address<=TABLE_BASE+6(index+1)+2, and go to S_HOP.
REQ-020 Compare updates are strictly greater or strictly less, so ties keep the earlier value.
REQ-021 In S_DONE: done=1 for exactly one cycle, then unconditionally go to S_IDLE.
REQ-022 Latency: if start is sampled at edge 0 with N neighbours, done is high between edge 2N+1 and edge 2N+2 (N=0 gives edge 1 to edge 2).
REQ-023 start is ignored outside S_IDLE.
REQ-024 start held high across S_DONE re-triggers on the first S_IDLE edge; there is no back-to-back restart from S_DONE.
REQ-025 mybestQ and mybestH hold their values after done until the next accepted start.
REQ-026 When en=0: state, address, index, mybestQ, mybestH and done all hold.
REQ-027 Resuming en=1 continues from the held state; data_in is re-sampled on the address still presented.
REQ-028 Count values above MAX_NEIGHBORS are clamped and never wrap the table address.
REQ-029 Index width is clog2(MAX_NEIGHBORS); address arithmetic is 11 bits and must not overflow for default parameters.

Reset
REQ-030 nrst=0 forces state=S_IDLE, address=0, index=0, count=0, hops=0, done=0, mybestQ=16'h0000 and mybestH=16'hFFFF, asynchronously.
REQ-031 Reset mid-scan abandons the scan with no done pulse; the first start after release begins a fresh scan.

Structure
REQ-032 WORD_WIDTH(16), MEM_DEPTH(2048), MEM_WIDTH(8), COUNT_ADDR, TABLE_BASE, entry stride (6) and field offsets SHALL live in a shared package used by bestNeighbors as well.
REQ-033 The state encoding SHALL be a package typedef.
REQ-034 The design is a single FSM plus datapath; no sub-module is required.

Verification
REQ-035 Count=3, entries (hops,Q)=(4,100),(2,300),(5,200), start at edge 0 -> done at edge 7 to 8, mybestQ=300, mybestH=2.
REQ-036 Count=0 -> done at edge 1 to 2, mybestQ=0, mybestH=16'hFFFF, no table address issued.
REQ-037 Count=40 with MAX_NEIGHBORS=16 -> exactly 16 entries read, last address TABLE_BASE+94, done at edge 33 to 34.
REQ-038 en low for 5 cycles during S_Q of entry 1 -> all outputs frozen; result identical to the REQ-035 result, 5 cycles later.
REQ-039 nrst pulse during entry 2 -> outputs return to reset values, no done pulse; a new start completes normally.
REQ-040 start asserted while busy, and tie cases with Q=300 twice -> busy start ignored, single done pulse, mybestQ=300.
